debug_port_tx: RTL and testbench

- Host-side transmitter for the CPU debug port.
- On a trigger it snapshots the parallel debug vector and sends it as one framed burst over an 8N1 UART line to the host debug script.
- Byte 0 of each frame is a sync byte inserted by this block; the CPU never drives byte 0 of the vector.
- Sits in the top level between the cpu debug_port_vector output and the board TX pin.

---
 rtl/debug_port_tx.sv | 115 +++++++++++
 tb/tb_debug_port_tx.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/debug_port_tx.sv
// Debug-port UART transmitter: snapshots the CPU debug vector on a trigger and
// sends it as one 8N1 burst, prefixed by a sync byte.
module debug_port_tx #(
  parameter int unsigned DEBUG_BYTES  = 32,
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic                         clk,
  input  logic                         nreset,
  input  logic                         trigger,
  input  logic [8:DEBUG_BYTES*8-1]     debug_port_vector,
  output logic                         uart_tx,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         overrun
);

  localparam int unsigned CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BYTE_W = $clog2(DEBUG_BYTES);
  localparam int unsigned SNAP_W = (DEBUG_BYTES - 1) * 8;

  localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(DEBUG_BYTES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state;
  logic [CNT_W-1:0]    baud_cnt;
  logic [2:0]          bit_idx;
  logic [BYTE_W-1:0]   byte_idx;
  logic [7:0]          shift;
  logic [SNAP_W-1:0]   snap;
  logic [SNAP_W-1:0]   snap_in;
  logic                baud_wrap;

  // Vector bytes are MSB-at-lowest-index; repack bytes 1..N-1 LSB-first so
  // byte 1 sits in snap_in[7:0] and later bytes shift down into place.
  for (genvar k = 1; k < DEBUG_BYTES; k++) begin : g_byte
    for (genvar j = 0; j < 8; j++) begin : g_bit
      assign snap_in[(k-1)*8 + j] = debug_port_vector[k*8 + 7 - j];
    end
  end

  assign baud_wrap = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (nreset) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      shift      <= '0;
      snap       <= '0;
      uart_tx    <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (trigger && state != IDLE) overrun <= 1'b1;
      if (state != IDLE) baud_cnt <= baud_wrap ? '0 : baud_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (trigger) begin
            state    <= START;
            baud_cnt <= '0;
            byte_idx <= '0;
            shift    <= SYNC_BYTE;
            snap     <= snap_in;
            uart_tx  <= 1'b0;
            busy     <= 1'b1;
          end
        end
        START: begin
          if (baud_wrap) begin
            state   <= DATA;
            bit_idx <= '0;
            uart_tx <= shift[0];
          end
        end
        DATA: begin
          if (baud_wrap) begin
            if (bit_idx == 3'd7) begin
              state   <= STOP;
              uart_tx <= 1'b1;
            end else begin
              // shift[1] is the next bit because shift[0] is already on the line
              bit_idx <= bit_idx + 1'b1;
              uart_tx <= shift[1];
              shift   <= shift >> 1;
            end
          end
        end
        STOP: begin
          if (baud_wrap) begin
            if (byte_idx != BYTE_LAST) begin
              byte_idx <= byte_idx + 1'b1;
              shift    <= snap[7:0];
              snap     <= snap >> 8;
              state    <= START;
              uart_tx  <= 1'b0;
            end else begin
              state      <= IDLE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_port_tx.sv
// Randomized self-checking bench for debug_port_tx (3-byte frames, 4 clocks/bit)
// against a per-cycle line model built from the frame bytes.
module tb_debug_port_tx;

  localparam int unsigned NB  = 3;
  localparam int unsigned CPB = 4;
  localparam int FRAME_CYC = NB * 10 * CPB;

  logic        clk = 1'b0;
  logic        nreset;
  logic        trigger;
  logic [15:0] dvec;
  logic        uart_tx;
  logic        busy;
  logic        frame_done;
  logic        overrun;

  int total = 0;
  int bad   = 0;
  logic exp_ovr;

  debug_port_tx #(
    .DEBUG_BYTES (NB),
    .CLKS_PER_BIT(CPB),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .clk              (clk),
    .nreset           (nreset),
    .trigger          (trigger),
    .debug_port_vector(dvec),
    .uart_tx          (uart_tx),
    .busy             (busy),
    .frame_done       (frame_done),
    .overrun          (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected line level in cycle c of a frame: each byte is 10 bit slots
  // (start, 8 data LSB first, stop), each slot CPB cycles long.
  function automatic logic exp_line(input logic [15:0] vec, input int c);
    logic [7:0] fb [3];
    int b;
    int pos;
    fb[0] = 8'hA5;
    fb[1] = vec[15:8];
    fb[2] = vec[7:0];
    b   = c / (10 * CPB);
    pos = (c % (10 * CPB)) / CPB;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return fb[2'(b)][3'(pos - 1)];
  endfunction

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      check("idle_tx", uart_tx, 1'b1);
      check("idle_busy", busy, 1'b0);
      check("idle_done", frame_done, 1'b0);
      check("idle_ovr", overrun, exp_ovr);
    end
  endtask

  // Called just after a negedge sample with the DUT idle (or in its frame_done cycle).
  task automatic send_frame(input logic [15:0] vec, input bit iso, input int ovr_cyc,
                            input bit hold, input bit keep_after, input int abort_at);
    dvec    = vec;
    trigger = 1'b1;
    for (int c = 0; c < FRAME_CYC; c++) begin
      @(negedge clk);
      check("tx", uart_tx, exp_line(vec, c));
      check("busy", busy, 1'b1);
      check("done_early", frame_done, 1'b0);
      check("ovr", overrun, exp_ovr);
      if (c == abort_at) begin
        nreset  = 1'b1;
        trigger = 1'b0;
        @(negedge clk);
        check("abort_tx", uart_tx, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_ovr", overrun, 1'b0);
        check("abort_done", frame_done, 1'b0);
        nreset  = 1'b0;
        exp_ovr = 1'b0;
        return;
      end
      trigger = hold || (c == ovr_cyc);
      if (trigger) exp_ovr = 1'b1;
      if (iso && c == 0) dvec = 16'hFFFF;
    end
    @(negedge clk);
    check("end_busy", busy, 1'b0);
    check("end_done", frame_done, 1'b1);
    check("end_tx", uart_tx, 1'b1);
    check("end_ovr", overrun, exp_ovr);
    trigger = keep_after;
  endtask

  initial begin
    logic [15:0] v;
    int oc;
    nreset  = 1'b1;
    trigger = 1'b0;
    dvec    = '0;
    exp_ovr = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_tx", uart_tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", frame_done, 1'b0);
    check("rst_ovr", overrun, 1'b0);
    nreset = 1'b0;
    idle_cycles(20);

    send_frame(16'h3C81, 1'b0, -1, 1'b0, 1'b0, -1);
    idle_cycles(3);

    send_frame(16'h3C81, 1'b1, -1, 1'b0, 1'b0, -1);
    idle_cycles(3);

    send_frame(16'hC35A, 1'b0, 10, 1'b0, 1'b0, -1);
    idle_cycles(20);

    send_frame(16'($urandom), 1'b0, -1, 1'b0, 1'b0, 50);
    idle_cycles(2);
    send_frame(16'h3C81, 1'b0, -1, 1'b0, 1'b0, -1);
    idle_cycles(2);

    send_frame(16'h1234, 1'b0, -1, 1'b1, 1'b1, -1);
    send_frame(16'hFE01, 1'b0, -1, 1'b1, 1'b0, -1);
    idle_cycles(5);

    nreset = 1'b1;
    @(negedge clk);
    check("clr_ovr", overrun, 1'b0);
    nreset  = 1'b0;
    exp_ovr = 1'b0;

    for (int i = 0; i < 8; i++) begin
      v  = 16'($urandom);
      oc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, FRAME_CYC - 1)) : -1;
      send_frame(v, 1'b0, oc, 1'b0, 1'b0, -1);
      idle_cycles(int'($urandom_range(0, 4)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
